// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
// Ports: none (package).
package spi_pkg;

  localparam int DEF_CLK_DIV = 25;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } spi_state_e;

  function automatic int cs_sel_w(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator for the SPI master.
// Ports: sys_clk, reset, load (reload), run (count enable), tick.
module spi_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = run && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load || tick) begin
      cnt_d = CW'(CLK_DIV - 1);
    end else if (run) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master, all four modes, ready/valid command/response.
// Ports: sys_clk, reset, enable, cmd_*, tx_data, cpol, cpha, cs_sel,
//        rsp_valid, rx_data, busy, sclk, mosi, miso, cs_n.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int NUM_CS   = 1,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 1,
  parameter int CS_SEL_W = cs_sel_w(NUM_CS)
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [CS_SEL_W-1:0] cs_sel,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rx_data,
  output logic                busy,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic [NUM_CS-1:0]   cs_n
);

  localparam int EDGES = 2 * DATA_W;
  localparam int M1 = (EDGES > CS_SETUP) ? EDGES : CS_SETUP;
  localparam int STEP_MAX = (M1 > CS_HOLD) ? M1 : CS_HOLD;
  localparam int STEP_W = $clog2(STEP_MAX + 1);

  spi_state_e state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic cpha_q, cpha_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic busy_q, busy_d;
  logic rsp_q, rsp_d;
  logic rdy_q, rdy_d;
  logic accept, tick, leading, last_edge;

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .sys_clk(sys_clk),
    .reset  (reset),
    .load   (accept),
    .run    (state_q != IDLE),
    .tick   (tick)
  );

  // rdy_q is only ever set while IDLE
  assign accept = cmd_valid && rdy_q;
  assign leading = ~step_q[0];
  assign last_edge = (step_q == STEP_W'(EDGES - 1));

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    step_d    = step_q;
    cs_n_d    = cs_n_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    rsp_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (accept) begin
          state_d = SETUP;
          tx_d    = tx_data;
          rx_d    = '0;
          step_d  = '0;
          cpha_d  = cpha;
          mosi_d  = cpha ? 1'b0 : tx_data[DATA_W-1];
          // out-of-range select leaves every line high
          for (int i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = (int'(cs_sel) != i);
          end
        end
      end
      SETUP: begin
        if (tick) begin
          if (step_q == STEP_W'(CS_SETUP - 1)) begin
            state_d = SHIFT;
            step_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          step_d = step_q + 1'b1;
          // sample on leading (cpha=0) or trailing (cpha=1)
          if (leading ^ cpha_q) begin
            rx_d = (rx_q << 1) | DATA_W'(miso);
          end else if (cpha_q) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end else if (!last_edge) begin
            tx_d   = tx_q << 1;
            mosi_d = tx_d[DATA_W-1];
          end
          if (last_edge) begin
            state_d = HOLD;
            step_d  = '0;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (step_q == STEP_W'(CS_HOLD - 1)) begin
            state_d = DONE;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        cs_n_d    = '1;
        mosi_d    = 1'b0;
        rx_data_d = rx_q;
        rsp_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    // ready returns one cycle after the response pulse
    rdy_d = enable && (state_d == IDLE) && (state_q != DONE);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      step_q    <= '0;
      cs_n_q    <= '1;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      rsp_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      step_q    <= step_d;
      cs_n_q    <= cs_n_d;
      cpha_q    <= cpha_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      rsp_q     <= rsp_d;
      rdy_q     <= rdy_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign rsp_valid = rsp_q;
  assign rx_data   = rx_data_q;
  assign busy      = busy_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Testbench for spi_master_param: directed and random transfers
// against a behavioural SPI slave, two parameter sets.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // instance 0: 16-bit, CLK_DIV 25, three chip selects
  logic        rst0 = 1'b0, en0 = 1'b1, cv0 = 1'b0;
  logic        cpol0 = 1'b0, cpha0 = 1'b0, miso0;
  logic [15:0] txd0 = '0;
  logic [1:0]  sel0 = '0;
  logic        rdy0, rv0, busy0, sclk0, mosi0;
  logic [15:0] rx0;
  logic [2:0]  csn0;

  spi_master_param #(.NUM_CS(3)) dut0 (
    .sys_clk(clk), .reset(rst0), .enable(en0),
    .cmd_valid(cv0), .cmd_ready(rdy0), .tx_data(txd0),
    .cpol(cpol0), .cpha(cpha0), .cs_sel(sel0),
    .rsp_valid(rv0), .rx_data(rx0), .busy(busy0),
    .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(csn0)
  );

  // instance 1: 8-bit, CLK_DIV 2, looped back
  logic       rst1 = 1'b0, en1 = 1'b1, cv1 = 1'b0;
  logic       cpol1 = 1'b0, cpha1 = 1'b0;
  logic [7:0] txd1 = '0;
  logic [0:0] sel1 = '0;
  logic       rdy1, rv1, busy1, sclk1, mosi1;
  logic [7:0] rx1;
  logic [0:0] csn1;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2)) dut1 (
    .sys_clk(clk), .reset(rst1), .enable(en1),
    .cmd_valid(cv1), .cmd_ready(rdy1), .tx_data(txd1),
    .cpol(cpol1), .cpha(cpha1), .cs_sel(sel1),
    .rsp_valid(rv1), .rx_data(rx1), .busy(busy1),
    .sclk(sclk1), .mosi(mosi1), .miso(mosi1), .cs_n(csn1)
  );

  // behavioural SPI slave on cs_n[0]
  bit          loop0 = 1'b1;
  logic        s_miso = 1'b0;
  logic        s_cpol = 1'b0, s_cpha = 1'b0;
  logic [15:0] s_reply = '0, s_out = '0, s_rx = '0;

  assign miso0 = loop0 ? mosi0 : s_miso;

  always @(negedge csn0[0]) begin
    s_rx  = '0;
    s_out = s_reply;
    if (!s_cpha) begin
      s_miso = s_out[15];
      s_out  = s_out << 1;
    end
  end

  always @(posedge sclk0 or negedge sclk0) begin
    if (csn0[0] === 1'b0) begin
      if ((sclk0 !== s_cpol) ^ s_cpha) begin
        s_rx = {s_rx[14:0], mosi0};
      end else begin
        s_miso = s_out[15];
        s_out  = s_out << 1;
      end
    end
  end

  int rises0 = 0;
  always @(posedge sclk0) if (csn0[0] === 1'b0) rises0++;

  logic [2:0] low0 = '0;
  always @(negedge clk) low0 |= ~csn0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer0(input logic [15:0] tx, input logic pol,
                       input logic pha, input logic [1:0] sel,
                       output int lat, output logic [15:0] rx);
    int n;
    @(negedge clk);
    cpol0 = pol; cpha0 = pha; s_cpol = pol; s_cpha = pha;
    sel0 = sel; txd0 = tx;
    repeat (2) @(negedge clk);
    n = 0;
    while (rdy0 !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 3000), 1);
    cv0 = 1'b1;
    @(posedge clk);
    #1 cv0 = 1'b0;
    lat = -1;
    rx = 'x;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (rv0 === 1'b1) begin
        lat = i;
        rx = rx0;
        break;
      end
    end
  endtask

  task automatic wait_rv0(output logic [15:0] rx);
    rx = 'x;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (rv0 === 1'b1) begin
        rx = rx0;
        break;
      end
    end
  endtask

  initial begin
    int lat, n, hi, m, r1, r2;
    logic [15:0] rx, tx, rep;
    logic pol, pha, prev, seen;

    // reset values
    #1 rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_csn", 32'(csn0), 32'h7);
    check("rst_sclk", 32'(sclk0), 0);
    check("rst_mosi", 32'(mosi0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_rv", 32'(rv0), 0);
    check("rst_rx", 32'(rx0), 0);
    check("rst_rdy", 32'(rdy0), 0);
    check("rst_csn1", 32'(csn1), 1);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // mode 0 loopback
    rises0 = 0;
    low0 = '0;
    xfer0(16'hA5C3, 1'b0, 1'b0, 2'd0, lat, rx);
    check("m0_rx", 32'(rx), 32'hA5C3);
    check("m0_lat", 32'(lat), 876);
    check("m0_rises", 32'(rises0), 16);
    check("m0_csmask", 32'(low0), 32'h1);
    check("m0_sclk_idle", 32'(sclk0), 0);
    check("m0_csn_end", 32'(csn0), 32'h7);

    // modes 1..3 and random transfers against the slave
    loop0 = 1'b0;
    for (int k = 1; k < 8; k++) begin
      if (k < 4) begin
        m = k;
        tx = 16'hBEEF;
        rep = 16'h1234;
      end else begin
        m = $urandom_range(0, 3);
        tx = 16'($urandom);
        rep = 16'($urandom);
      end
      pol = m[1];
      pha = m[0];
      s_reply = rep;
      xfer0(tx, pol, pha, 2'd0, lat, rx);
      check("mode_rx", 32'(rx), 32'(rep));
      check("mode_slave_rx", 32'(s_rx), 32'(tx));
      check("mode_lat", 32'(lat), 876);
      @(negedge clk);
      check("mode_sclk_idle", 32'(sclk0), 32'(pol));
    end
    loop0 = 1'b1;

    // chip-select decode
    low0 = '0;
    xfer0(16'h1357, 1'b0, 1'b0, 2'd2, lat, rx);
    check("cs2_mask", 32'(low0), 32'h4);
    check("cs2_rx", 32'(rx), 32'h1357);
    low0 = '0;
    xfer0(16'h2468, 1'b0, 1'b0, 2'd3, lat, rx);
    check("cs3_mask", 32'(low0), 32'h0);
    check("cs3_lat", 32'(lat), 876);
    check("cs3_rx", 32'(rx), 32'h2468);

    // reset mid-transfer
    @(negedge clk);
    cpol0 = 1'b0; cpha0 = 1'b0; sel0 = 2'd0; txd0 = 16'hC3A5;
    n = 0;
    while (rdy0 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    rises0 = 0;
    cv0 = 1'b1;
    @(posedge clk);
    #1 cv0 = 1'b0;
    n = 0;
    while (rises0 < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_reach", 32'(rises0), 5);
    #2 rst0 = 1'b1;
    #1;
    check("rstmid_csn", 32'(csn0), 32'h7);
    check("rstmid_busy", 32'(busy0), 0);
    check("rstmid_sclk", 32'(sclk0), 0);
    check("rstmid_rv", 32'(rv0), 0);
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (rv0 === 1'b1) seen = 1'b1;
    end
    check("rstmid_no_rsp", 32'(seen), 0);
    xfer0(16'h00FF, 1'b0, 1'b0, 2'd0, lat, rx);
    check("rstmid_next_rx", 32'(rx), 32'h00FF);
    check("rstmid_next_lat", 32'(lat), 876);

    // enable gating and back-to-back
    @(negedge clk);
    txd0 = 16'h1111;
    n = 0;
    while (rdy0 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cv0 = 1'b1;
    @(posedge clk);
    #1 txd0 = 16'h2222;
    check("en_busy", 32'(busy0), 1);
    repeat (5) @(negedge clk);
    en0 = 1'b0;
    wait_rv0(rx);
    check("en_first_rx", 32'(rx), 32'h1111);
    repeat (20) @(negedge clk);
    check("en_blocked_busy", 32'(busy0), 0);
    check("en_blocked_rdy", 32'(rdy0), 0);
    check("en_blocked_csn", 32'(csn0), 32'h7);
    en0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (busy0 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("en_second_accept", 32'(seen), 1);
    txd0 = 16'h3333;
    wait_rv0(rx);
    check("en_second_rx", 32'(rx), 32'h2222);
    hi = (csn0 === 3'b111) ? 1 : 0;
    @(posedge clk);
    #1;
    check("b2b_rdy", 32'(rdy0), 1);
    if (csn0 === 3'b111) hi++;
    @(posedge clk);
    #1 cv0 = 1'b0;
    check("b2b_accept", 32'(busy0), 1);
    check("b2b_csn_low", 32'(csn0), 32'h6);
    check("b2b_gap", 32'(hi >= 2), 1);
    wait_rv0(rx);
    check("b2b_third_rx", 32'(rx), 32'h3333);

    // small instance: CLK_DIV 2, 8 bits
    @(negedge clk);
    txd1 = 8'h81;
    repeat (2) @(negedge clk);
    n = 0;
    while (rdy1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cv1 = 1'b1;
    @(posedge clk);
    #1 cv1 = 1'b0;
    prev = sclk1;
    r1 = -1;
    r2 = -1;
    lat = -1;
    rx = 'x;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (sclk1 && !prev) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev = sclk1;
      if (rv1 === 1'b1) begin
        lat = i;
        rx = 16'(rx1);
        break;
      end
    end
    check("d1_lat", 32'(lat), 39);
    check("d1_rx", 32'(rx), 32'h81);
    check("d1_period", 32'(r2 - r1), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master for HDP-1280-2 register access and future SPI peripherals on the board.
- Fully synchronous to sys_clk; SCLK is generated from a half-period tick, not a divided clock domain.
- Configurable word width, clock divider, chip-select count and CS setup/hold; all four SPI modes selected per transfer.
- Ready/valid command and response interface replaces start/busy polling.

Parameters:
DATA_W, 16, bits per transfer (1..32), MSB first
CLK_DIV, 25, sys_clk cycles per SCLK half-period (>=2); 25 gives 1 MHz from 50 MHz
NUM_CS, 1, number of chip-select lines (1..8)
CS_SETUP, 2, SCLK half-periods from CS low to first SCLK edge (>=1)
CS_HOLD, 1, SCLK half-periods from last SCLK edge to CS high (>=1)

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-high
enable  in  1  gates acceptance of new commands only
cmd_valid  in  1  command request
cmd_ready  out  1  high when enable=1 and state IDLE
tx_data  in  DATA_W  word to send; latched on accept
cpol  in  1  clock polarity; latched on accept, also sets idle SCLK level
cpha  in  1  clock phase; latched on accept
cs_sel  in  CS_SEL_W  chip-select index; latched on accept
rsp_valid  out  1  one-cycle pulse, rx_data valid
rx_data  out  DATA_W  received word; holds until the next rsp_valid
busy  out  1  high in any state other than IDLE
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in (synchronised externally)
cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset values: cs_n all 1, sclk 0, mosi 0, busy 0, rsp_valid 0, rx_data 0, cmd_ready 0, state IDLE, latched config 0.
- All SPI outputs come from flops; no combinational paths to pins.
- Half-period tick:
  - Counter reloads to CLK_DIV-1 on accept and on every tick.
  - Counter is frozen in IDLE.
  - Tick fires when the counter is 0.
- FSM states:
  - IDLE: sclk follows registered cpol input. Accept on cmd_valid && cmd_ready, then latch inputs and go to SETUP.
  - SETUP: cs_n[sel]=0. If cpha=0, mosi = bit DATA_W-1. Leave after CS_SETUP ticks and go to SHIFT.
  - SHIFT: sclk toggles on each tick, 2*DATA_W edges. Edges alternate leading/trailing.
    - cpha=0: leading edge samples miso; trailing edge shifts out the next bit, except after the last bit.
    - cpha=1: leading edge shifts out a bit (first leading edge drives the MSB); trailing edge samples miso.
    - After the final edge sclk equals cpol; go to HOLD.
  - HOLD: cs_n stays low, mosi holds. Leave after CS_HOLD ticks and go to DONE.
  - DONE (one cycle): cs_n all 1, mosi 0, rx_data <= rx shift register, rsp_valid=1, then IDLE.
- Sampling: miso is captured on the sys_clk edge that updates sclk to the sampling edge.
- Latency: rsp_valid is high exactly (CS_SETUP + 2*DATA_W + CS_HOLD)*CLK_DIV + 1 cycles after the accepting edge. Defaults give 876.
- Back-to-back: cmd_ready rises the cycle after rsp_valid. cs_n is high for at least 2 sys_clk cycles between transfers.
- cmd_valid while busy is ignored, not queued.
- Changes to cpol/cpha/cs_sel/tx_data mid-transfer have no effect.
- enable=0 mid-transfer: the transfer completes; only new accepts are blocked.
- cs_sel >= NUM_CS: command is accepted and timed normally, no cs_n asserted, rx_data still returned.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous); no rsp_valid is generated. Next command after release behaves normally.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, SETUP, SHIFT, HOLD, DONE)
  - CS_SEL_W = max(1, clog2(NUM_CS)) helper
  - default CLK_DIV constant for the 50 MHz system
- Sub-module spi_tick_gen: half-period counter with load/run inputs and tick output.
- Shift and FSM logic stay in spi_master_param.

Test Plan:
1. Defaults, mode 0, tx_data=0xA5C3, miso looped to mosi -> rx_data=0xA5C3, rsp_valid at cycle 876, exactly 16 rising sclk edges while cs_n[0]=0, sclk idle 0.
2. Modes 1, 2 and 3, slave model returns 0x1234 per its mode, tx 0xBEEF -> slave receives 0xBEEF, rx_data=0x1234 each mode, sclk idles at cpol.
3. NUM_CS=3: cs_sel=2 -> only cs_n[2] low; cs_sel=3 -> cs_n=3'b111 throughout, rsp_valid still at cycle 876.
4. Reset pulsed after the 5th sampled bit -> same cycle cs_n all 1, busy 0, sclk 0, no rsp_valid; next transfer of 0x00FF returns the correct rx_data.
5. cmd_valid held with two words; enable=0 during the first transfer -> first completes, second not accepted until enable=1; with enable=1, second accepted the cycle after rsp_valid, cs_n high >=2 cycles between transfers.
6. CLK_DIV=2, DATA_W=8, mode 0, tx 0x81 looped back -> sclk period 4 cycles, rx_data=0x81, rsp_valid at cycle 39.
